// File: rtl/rv32_mem_arbiter_if.sv
// Signal bundle between the IF/LS requesters, the arbiter and the single memory port.
// slave is the arbiter's view; master is the surrounding core/memory view.
interface rv32_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              if_err;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic [STRB_W-1:0] ls_strb;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;
  logic              ls_err;

  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [STRB_W-1:0] m_strb;
  logic              m_gnt;
  logic              m_rvalid;
  logic [DATA_W-1:0] m_rdata;

  logic              stray;

  modport slave (
    input  if_req, if_addr,
    input  ls_req, ls_we, ls_addr, ls_wdata, ls_strb,
    input  m_gnt, m_rvalid, m_rdata,
    output if_gnt, if_rvalid, if_rdata, if_err,
    output ls_gnt, ls_rvalid, ls_rdata, ls_err,
    output m_req, m_we, m_addr, m_wdata, m_strb,
    output stray
  );

  modport master (
    output if_req, if_addr,
    output ls_req, ls_we, ls_addr, ls_wdata, ls_strb,
    output m_gnt, m_rvalid, m_rdata,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    input  ls_gnt, ls_rvalid, ls_rdata, ls_err,
    input  m_req, m_we, m_addr, m_wdata, m_strb,
    input  stray
  );
endinterface

// File: rtl/rv32_mem_arbiter.sv
// Round-robin IF/LS arbiter onto one memory port, one transaction outstanding, grant combinational on m_gnt.
// Response returns same cycle as m_rvalid; a watchdog errors out after TIMEOUT busy cycles; unselected requester waits.
module rv32_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst_n,
  rv32_mem_arbiter_if.slave bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  // count starts at 0 in the first busy cycle, so the TIMEOUT-th busy cycle sees TIMEOUT-1
  localparam logic [CNT_W-1:0] WD_FIRE = CNT_W'(TIMEOUT - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;
  localparam logic       OWN_IF = 1'b0;
  localparam logic       OWN_LS = 1'b1;

  logic [0:0]        state;
  logic              owner;
  logic              last;
  logic              stray_q;
  logic [CNT_W-1:0]  count;

  logic              idle;
  logic              busy;
  logic              sel;
  logic              req_any;
  logic              accept;
  logic              wd_fire;
  logic              done;
  logic [ADDR_W-1:0] sel_addr;
  logic [STRB_W-1:0] sel_strb;
  logic [DATA_W-1:0] resp_data;

  // Outputs are gated by rst_n so nothing is granted or returned while reset is held
  assign idle = rst_n && (state == S_IDLE);
  assign busy = rst_n && (state == S_BUSY);

  always_comb begin
    sel = OWN_IF;
    if (bus.if_req && bus.ls_req) begin
      sel = ~last;
    end else if (bus.ls_req) begin
      sel = OWN_LS;
    end
  end

  assign req_any  = idle && (bus.if_req || bus.ls_req);
  assign accept   = req_any && bus.m_gnt;
  assign sel_addr = (sel == OWN_LS) ? bus.ls_addr : bus.if_addr;
  assign sel_strb = (sel == OWN_LS) ? bus.ls_strb : '0;

  assign bus.m_req   = req_any;
  assign bus.m_we    = req_any && (sel == OWN_LS) && bus.ls_we;
  assign bus.m_addr  = req_any ? sel_addr : '0;
  assign bus.m_strb  = req_any ? sel_strb : '0;
  assign bus.m_wdata = (req_any && (sel == OWN_LS)) ? bus.ls_wdata : '0;

  assign bus.if_gnt = accept && (sel == OWN_IF);
  assign bus.ls_gnt = accept && (sel == OWN_LS);

  // A real response in the watchdog's final cycle wins over the error
  assign wd_fire   = busy && (count == WD_FIRE);
  assign done      = busy && (bus.m_rvalid || wd_fire);
  assign resp_data = bus.m_rvalid ? bus.m_rdata : '0;

  assign bus.if_rvalid = done && (owner == OWN_IF);
  assign bus.ls_rvalid = done && (owner == OWN_LS);
  assign bus.if_err    = done && (owner == OWN_IF) && !bus.m_rvalid;
  assign bus.ls_err    = done && (owner == OWN_LS) && !bus.m_rvalid;
  assign bus.if_rdata  = resp_data;
  assign bus.ls_rdata  = resp_data;
  assign bus.stray     = stray_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      owner   <= OWN_IF;
      last    <= OWN_LS;
      count   <= '0;
      stray_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.m_rvalid) begin
            stray_q <= 1'b1;
          end
          if (accept) begin
            state <= S_BUSY;
            owner <= sel;
            last  <= sel;
            count <= '0;
          end
        end
        default: begin
          if (done) begin
            state <= S_IDLE;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Directed scenarios plus a randomized run checked against a transaction-level model of the arbiter.
module tb_rv32_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TMO    = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rv32_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  rv32_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Transaction-level model: owner 0=none 1=IF 2=LS, age = busy cycle number (1 = first)
  int   m_owner;
  int   m_age;
  logic m_last_ls;
  logic m_stray;
  logic if_pend;
  logic ls_pend;

  // [7]if_gnt [6]ls_gnt [5]m_req [4]if_rvalid [3]ls_rvalid [2]if_err [1]ls_err [0]stray
  function automatic logic [7:0] obs_flags();
    return {bus.if_gnt, bus.ls_gnt, bus.m_req, bus.if_rvalid, bus.ls_rvalid,
            bus.if_err, bus.ls_err, bus.stray};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.ls_req   = 1'b0;
    bus.ls_we    = 1'b0;
    bus.ls_addr  = '0;
    bus.ls_wdata = '0;
    bus.ls_strb  = '0;
    bus.m_gnt    = 1'b0;
    bus.m_rvalid = 1'b0;
    bus.m_rdata  = '0;
  endtask

  task automatic pulse_reset();
    clear_inputs();
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.if_req   = 1'b1;
    bus.ls_req   = 1'b1;
    bus.m_gnt    = 1'b1;
    bus.m_rvalid = 1'b1;
    tick();
    settle();
    n_checks++;
    if (obs_flags() !== 8'h00) $display("FAIL reset_flags: got %b want %b", obs_flags(), 8'h00);
    else n_pass++;
    n_checks++;
    if ({bus.m_we, bus.m_strb} !== 5'h00) $display("FAIL reset_mwe_strb: got %h want 00", {bus.m_we, bus.m_strb});
    else n_pass++;
    clear_inputs();
    tick();
    rst_n = 1'b1;
    tick();
    settle();
    n_checks++;
    if (obs_flags() !== 8'h00) $display("FAIL reset_release_flags: got %b want %b", obs_flags(), 8'h00);
    else n_pass++;
  endtask

  task automatic test_single_if_read();
    tick();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    bus.m_gnt   = 1'b1;
    settle();
    n_checks++;
    if (obs_flags() !== 8'b1010_0000) $display("FAIL ifrd_gnt: got %b want %b", obs_flags(), 8'b1010_0000);
    else n_pass++;
    n_checks++;
    if ({bus.m_we, bus.m_addr, bus.m_strb} !== {1'b0, 32'h100, 4'h0})
      $display("FAIL ifrd_payload: got we=%b addr=%h strb=%h want we=0 addr=100 strb=0", bus.m_we, bus.m_addr, bus.m_strb);
    else n_pass++;
    tick();
    bus.if_req = 1'b0;
    bus.m_gnt  = 1'b0;
    settle();
    n_checks++;
    if (obs_flags() !== 8'h00) $display("FAIL ifrd_busy: got %b want %b", obs_flags(), 8'h00);
    else n_pass++;
    tick();
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = 32'hDEADBEEF;
    settle();
    n_checks++;
    if (obs_flags() !== 8'b0001_0000) $display("FAIL ifrd_resp: got %b want %b", obs_flags(), 8'b0001_0000);
    else n_pass++;
    n_checks++;
    if (bus.if_rdata !== 32'hDEADBEEF) $display("FAIL ifrd_data: got %h want deadbeef", bus.if_rdata);
    else n_pass++;
    tick();
    bus.m_rvalid = 1'b0;
    settle();
    n_checks++;
    if (obs_flags() !== 8'h00) $display("FAIL ifrd_idle: got %b want %b", obs_flags(), 8'h00);
    else n_pass++;
    tick();
    clear_inputs();
  endtask

  task automatic test_contention();
    logic [1:0] exp_g;
    pulse_reset();
    bus.if_req  = 1'b1;
    bus.ls_req  = 1'b1;
    bus.if_addr = 32'h1000;
    bus.ls_addr = 32'h2000;
    bus.m_gnt   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
      bus.m_rvalid = 1'b0;
      settle();
      n_checks++;
      if ({bus.if_gnt, bus.ls_gnt} !== exp_g) $display("FAIL rr_gnt%0d: got %b want %b", i, {bus.if_gnt, bus.ls_gnt}, exp_g);
      else n_pass++;
      n_checks++;
      if (bus.m_addr !== ((i % 2 == 0) ? 32'h1000 : 32'h2000)) $display("FAIL rr_addr%0d: got %h", i, bus.m_addr);
      else n_pass++;
      tick();
      bus.m_rvalid = 1'b1;
      bus.m_rdata  = 32'hC0DE0000 + i;
      settle();
      n_checks++;
      if ({bus.if_rvalid, bus.ls_rvalid, bus.m_req} !== {exp_g, 1'b0})
        $display("FAIL rr_resp%0d: got %b want %b", i, {bus.if_rvalid, bus.ls_rvalid, bus.m_req}, {exp_g, 1'b0});
      else n_pass++;
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_store_backpressure();
    bus.ls_req   = 1'b1;
    bus.ls_we    = 1'b1;
    bus.ls_addr  = 32'h204;
    bus.ls_wdata = 32'h000000AB;
    bus.ls_strb  = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      bus.m_gnt = (c == 3);
      settle();
      n_checks++;
      if (obs_flags() !== ((c == 3) ? 8'b0110_0000 : 8'b0010_0000))
        $display("FAIL st_gnt_c%0d: got %b", c, obs_flags());
      else n_pass++;
      n_checks++;
      if ({bus.m_we, bus.m_addr, bus.m_wdata, bus.m_strb} !== {1'b1, 32'h204, 32'h000000AB, 4'b0001})
        $display("FAIL st_payload_c%0d: got we=%b addr=%h wdata=%h strb=%b", c, bus.m_we, bus.m_addr, bus.m_wdata, bus.m_strb);
      else n_pass++;
      tick();
    end
    clear_inputs();
    for (int c = 0; c < 2; c++) begin
      settle();
      n_checks++;
      if (obs_flags() !== 8'h00) $display("FAIL st_wait%0d: got %b want 00000000", c, obs_flags());
      else n_pass++;
      tick();
    end
    bus.m_rvalid = 1'b1;
    settle();
    n_checks++;
    if (obs_flags() !== 8'b0000_1000) $display("FAIL st_ack: got %b want %b", obs_flags(), 8'b0000_1000);
    else n_pass++;
    tick();
    clear_inputs();
  endtask

  task automatic test_watchdog();
    bus.ls_req  = 1'b1;
    bus.ls_addr = $urandom;
    bus.m_gnt   = 1'b1;
    settle();
    n_checks++;
    if (obs_flags() !== 8'b0110_0000) $display("FAIL wd_gnt: got %b want %b", obs_flags(), 8'b0110_0000);
    else n_pass++;
    tick();
    clear_inputs();
    for (int k = 1; k < TMO; k++) begin
      settle();
      n_checks++;
      if (obs_flags() !== 8'h00) $display("FAIL wd_wait%0d: got %b want 00000000", k, obs_flags());
      else n_pass++;
      tick();
    end
    settle();
    n_checks++;
    if (obs_flags() !== 8'b0000_1010) $display("FAIL wd_fire: got %b want %b", obs_flags(), 8'b0000_1010);
    else n_pass++;
    n_checks++;
    if (bus.ls_rdata !== 32'h0) $display("FAIL wd_rdata: got %h want 0", bus.ls_rdata);
    else n_pass++;
    tick();
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = 32'h5555AAAA;
    settle();
    n_checks++;
    if (obs_flags() !== 8'h00) $display("FAIL wd_late: got %b want 00000000", obs_flags());
    else n_pass++;
    tick();
    bus.m_rvalid = 1'b0;
    bus.if_req   = 1'b1;
    bus.m_gnt    = 1'b1;
    settle();
    n_checks++;
    if (obs_flags() !== 8'b1010_0001) $display("FAIL wd_stray_regnt: got %b want %b", obs_flags(), 8'b1010_0001);
    else n_pass++;
    tick();
    clear_inputs();
    bus.m_rvalid = 1'b1;
    settle();
    n_checks++;
    if (obs_flags() !== 8'b0001_0001) $display("FAIL wd_after_resp: got %b want %b", obs_flags(), 8'b0001_0001);
    else n_pass++;
    tick();
    clear_inputs();
  endtask

  task automatic test_collision();
    pulse_reset();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h300;
    bus.m_gnt   = 1'b1;
    settle();
    n_checks++;
    if (obs_flags() !== 8'b1010_0000) $display("FAIL col_gnt: got %b want %b", obs_flags(), 8'b1010_0000);
    else n_pass++;
    tick();
    clear_inputs();
    repeat (TMO - 1) tick();
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = 32'h12345678;
    settle();
    n_checks++;
    if (obs_flags() !== 8'b0001_0000) $display("FAIL col_resp: got %b want %b", obs_flags(), 8'b0001_0000);
    else n_pass++;
    n_checks++;
    if (bus.if_rdata !== 32'h12345678) $display("FAIL col_data: got %h want 12345678", bus.if_rdata);
    else n_pass++;
    tick();
    bus.m_rvalid = 1'b0;
    settle();
    n_checks++;
    if (obs_flags() !== 8'h00) $display("FAIL col_after: got %b want 00000000", obs_flags());
    else n_pass++;
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid_busy();
    bus.if_req = 1'b1;
    bus.m_gnt  = 1'b1;
    settle();
    n_checks++;
    if (obs_flags() !== 8'b1010_0000) $display("FAIL rmb_gnt: got %b want %b", obs_flags(), 8'b1010_0000);
    else n_pass++;
    tick();
    clear_inputs();
    settle();
    rst_n        = 1'b0;
    bus.m_rvalid = 1'b1;
    bus.ls_req   = 1'b1;
    bus.m_gnt    = 1'b1;
    settle();
    n_checks++;
    if (obs_flags() !== 8'h00) $display("FAIL rmb_inreset: got %b want 00000000", obs_flags());
    else n_pass++;
    tick();
    tick();
    clear_inputs();
    rst_n = 1'b1;
    tick();
    bus.m_rvalid = 1'b1;
    settle();
    n_checks++;
    if (obs_flags() !== 8'h00) $display("FAIL rmb_late: got %b want 00000000", obs_flags());
    else n_pass++;
    tick();
    bus.m_rvalid = 1'b0;
    bus.if_req   = 1'b1;
    bus.m_gnt    = 1'b1;
    settle();
    n_checks++;
    if (obs_flags() !== 8'b1010_0001) $display("FAIL rmb_regnt: got %b want %b", obs_flags(), 8'b1010_0001);
    else n_pass++;
    tick();
    clear_inputs();
    bus.m_rvalid = 1'b1;
    settle();
    n_checks++;
    if (obs_flags() !== 8'b0001_0001) $display("FAIL rmb_resp: got %b want %b", obs_flags(), 8'b0001_0001);
    else n_pass++;
    tick();
    clear_inputs();
  endtask

  task automatic test_random();
    logic [7:0]  e;
    logic        pick_ls;
    logic [31:0] e_rdata;
    int          errs;
    pulse_reset();
    m_owner = 0; m_age = 0; m_last_ls = 1'b1; m_stray = 1'b0;
    if_pend = 1'b0; ls_pend = 1'b0;
    errs = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      tick();
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1'b1;
        bus.if_addr = $urandom;
      end
      if (!ls_pend && $urandom_range(0, 2) == 0) begin
        ls_pend = 1'b1;
        bus.ls_addr  = $urandom;
        bus.ls_we    = 1'($urandom_range(0, 1));
        bus.ls_wdata = $urandom;
        bus.ls_strb  = 4'($urandom_range(0, 15));
      end
      bus.if_req   = if_pend;
      bus.ls_req   = ls_pend;
      bus.m_gnt    = ($urandom_range(0, 3) != 0);
      bus.m_rvalid = (m_owner != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0);
      bus.m_rdata  = $urandom;
      settle();

      e = '0; pick_ls = 1'b0; e_rdata = '0;
      if (m_owner == 0) begin
        pick_ls = (bus.if_req && bus.ls_req) ? !m_last_ls : bus.ls_req;
        if (bus.if_req || bus.ls_req) begin
          e[5] = 1'b1;
          if (bus.m_gnt) e[pick_ls ? 6 : 7] = 1'b1;
        end
      end else if (bus.m_rvalid || m_age == TMO) begin
        e[(m_owner == 1) ? 4 : 3] = 1'b1;
        if (!bus.m_rvalid) e[(m_owner == 1) ? 2 : 1] = 1'b1;
        e_rdata = bus.m_rvalid ? bus.m_rdata : 32'h0;
      end
      e[0] = m_stray;

      n_checks++;
      if (obs_flags() !== e) begin
        errs++;
        if (errs <= 10) $display("FAIL rnd_flags@%0d: got %b want %b", cyc, obs_flags(), e);
      end else n_pass++;
      if (e[5]) begin
        n_checks++;
        if ({bus.m_we, bus.m_addr, bus.m_strb} !== (pick_ls ? {bus.ls_we, bus.ls_addr, bus.ls_strb} : {1'b0, bus.if_addr, 4'h0})) begin
          errs++;
          if (errs <= 10) $display("FAIL rnd_payload@%0d: got we=%b addr=%h strb=%h", cyc, bus.m_we, bus.m_addr, bus.m_strb);
        end else n_pass++;
        if (pick_ls) begin
          n_checks++;
          if (bus.m_wdata !== bus.ls_wdata) begin
            errs++;
            if (errs <= 10) $display("FAIL rnd_wdata@%0d: got %h want %h", cyc, bus.m_wdata, bus.ls_wdata);
          end else n_pass++;
        end
      end
      if (e[4] || e[3]) begin
        n_checks++;
        if ((e[4] ? bus.if_rdata : bus.ls_rdata) !== e_rdata) begin
          errs++;
          if (errs <= 10) $display("FAIL rnd_rdata@%0d: got %h want %h", cyc, e[4] ? bus.if_rdata : bus.ls_rdata, e_rdata);
        end else n_pass++;
      end

      if (m_owner == 0) begin
        if (bus.m_rvalid) m_stray = 1'b1;
        if (e[7]) begin
          m_owner = 1; m_age = 1; m_last_ls = 1'b0; if_pend = 1'b0;
        end else if (e[6]) begin
          m_owner = 2; m_age = 1; m_last_ls = 1'b1; ls_pend = 1'b0;
        end
      end else if (e[4] || e[3]) begin
        m_owner = 0;
      end else begin
        m_age++;
      end
    end
    tick();
    clear_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single_if_read();
    test_contention();
    test_store_backpressure();
    test_watchdog();
    test_collision();
    test_reset_mid_busy();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/rv32_mem_arbiter.md
Name: rv32_mem_arbiter

Overview:
- Shares one unified memory/bus port between the core's instruction-fetch requester (IF) and its load/store requester (LS).
- Round-robin arbitration with exactly one outstanding transaction; responses are routed back to the granted requester.
- A watchdog returns an error if memory never answers.
- Sits between the multi-cycle control/datapath (fetch in S_FETCH, data access in S_MEM) and the single-port memory interface.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byte strobes = DATA_W/8)
TIMEOUT, 255, max cycles in BUSY before watchdog error; must be ≥1, counter width = clog2(TIMEOUT+1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
if_req  in  1  IF read request
if_addr  in  ADDR_W  IF address
if_gnt  out  1  IF request accepted this cycle
if_rvalid  out  1  IF response valid (1-cycle pulse)
if_rdata  out  DATA_W  IF read data
if_err  out  1  IF response is watchdog error (qualified by if_rvalid)
ls_req  in  1  LS request
ls_we  in  1  LS write (1) / read (0)
ls_addr  in  ADDR_W  LS address
ls_wdata  in  DATA_W  LS write data
ls_strb  in  DATA_W/8  LS byte strobes
ls_gnt  out  1  LS request accepted
ls_rvalid  out  1  LS response/write-ack valid
ls_rdata  out  DATA_W  LS read data
ls_err  out  1  LS watchdog error (qualified by ls_rvalid)
m_req  out  1  memory request
m_we  out  1  memory write
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_strb  out  DATA_W/8  memory strobes
m_gnt  in  1  memory accepts request this cycle
m_rvalid  in  1  memory response (reads and write acks)
m_rdata  in  DATA_W  memory read data
stray  out  1  sticky: m_rvalid received with nothing outstanding

Behaviour:
- Clock and reset: clk; reset rst_n, asynchronous, active-low.
- Reset values: state=IDLE, owner=IF, last=LS (IF wins first tie), watchdog count=0, stray=0. All gnt/rvalid/err outputs are 0 in reset.
- States:
  - IDLE: no transaction outstanding.
  - BUSY: one transaction outstanding; owner recorded.
- IDLE arbitration (combinational select):
  - Only if_req: select IF.
  - Only ls_req: select LS.
  - Both: select the requester ≠ last.
  - m_req = if_req|ls_req.
  - m_addr/m_we/m_wdata/m_strb driven from the selected requester. IF always drives m_we=0, m_strb=0; m_wdata is don't-care for IF.
- Acceptance: in IDLE, selected gnt = m_gnt & m_req. On that edge: state→BUSY, owner←sel, last←sel, count←0.
- Requester hold rule: requesters hold req and payload stable until gnt. An unselected requester keeps waiting; no gnt is given.
- BUSY:
  - m_req=0, both gnt=0; count increments each cycle.
  - On m_rvalid: owner's rvalid=1 for that cycle, rdata=m_rdata, err=0; state→IDLE. No new grant in that same cycle.
  - Minimum issue rate: one transaction per 2 cycles.
- Watchdog: if count reaches TIMEOUT with no m_rvalid, owner's rvalid=1, err=1, rdata=0; state→IDLE.
- Non-owner outputs: the non-owner's rvalid=0 always. rdata outputs may carry m_rdata unconditionally; only rvalid-qualified values matter.
- Stray responses: m_rvalid in IDLE (late response after watchdog, or after reset mid-transaction) is dropped and sets stray=1. stray clears only on reset.
- Watchdog and response in the same cycle (count==TIMEOUT & m_rvalid): the real response wins, err=0.
- Reset mid-BUSY: the transaction is abandoned with no rvalid to either requester; a later m_rvalid sets stray.
- Write responses: a write completes only on m_rvalid (write-ack); LS waits for ls_rvalid even for stores.

Test Plan:
- Single IF read: if_req=1, if_addr=0x100, m_gnt=1 → if_gnt pulse cycle 0, m_addr=0x100, m_we=0; m_rvalid cycle 2 with 0xDEADBEEF → if_rvalid=1, if_rdata=0xDEADBEEF, if_err=0, ls_rvalid=0.
- Contention round-robin: both req held after reset, m_gnt=1, immediate responses → grant order IF, LS, IF, LS; no requester granted twice consecutively while the other waits.
- LS store with backpressure: ls_we=1, addr=0x204, wdata=0x000000AB, strb=4'b0001, m_gnt low 3 cycles → ls_gnt only on the first m_gnt=1 cycle; m_* payload stable throughout; ls_rvalid on write-ack.
- Watchdog: TIMEOUT=4, LS read granted, no m_rvalid → ls_rvalid=1, ls_err=1 exactly 4 cycles after grant; state back to IDLE. A later m_rvalid sets stray=1 with no rvalid pulses.
- Collision: m_rvalid arrives on the cycle count==TIMEOUT → err=0, data delivered, stray stays 0.
- Reset mid-BUSY: assert rst_n=0 while IF is outstanding → all outputs 0 immediately. After release, a late m_rvalid sets stray=1; the next if_req is granted normally.
